// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared state encoding, nop/reset constants and MIPS field bit ranges
package fetch_queue_pkg;
    typedef enum logic {FQ_NORMAL, FQ_WAIT_DS} fq_state_e;
    localparam logic [31:0] NOP_INS  = 32'h0;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int SH_HI   = 10;
    localparam int SH_LO   = 6;
    localparam int FN_HI   = 5;
    localparam int FN_LO   = 0;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int ADDR_HI = 25;
    localparam int ADDR_LO = 0;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side, decode-side and redirect signals of the fetch queue
interface fetch_queue_if #(parameter int DEPTH = 4, parameter int PC_W = 32);
    localparam int CW = $clog2(DEPTH) + 1;
    logic            in_valid;
    logic [31:0]     in_ins;
    logic [PC_W-1:0] in_pc;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_ins;
    logic [PC_W-1:0] out_pc;
    logic [PC_W-1:0] out_pc8;
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm16;
    logic [25:0]     addr26;
    logic            flush;
    logic            keep_ds;
    logic [CW-1:0]   count;
    modport master (
        output in_valid, in_ins, in_pc, out_ready, flush, keep_ds,
        input  in_ready, out_valid, out_ins, out_pc, out_pc8, op, rs, rt, rd, shamt, funct,
               imm16, addr26, count
    );
    modport slave (
        input  in_valid, in_ins, in_pc, out_ready, flush, keep_ds,
        output in_ready, out_valid, out_ins, out_pc, out_pc8, op, rs, rt, rd, shamt, funct,
               imm16, addr26, count
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH-entry register array, one synchronous write port, one asynchronous read port
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    // storage is only written on enqueue; flushes move pointers, never contents
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch-to-decode instruction queue with delay-slot-preserving flush (optional FETCH_QUEUE_PERF_EN counters)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    fetch_queue_if.slave fq
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flushed
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d, nxt_rd;
    logic [CW-1:0]      cnt_q, cnt_d, avail;
    fq_state_e          st_q, st_d;
    logic               enq, deq, hard, keep, avail_nz;
    logic [31:0]        head_ins, ins;
    logic [PC_W-1:0]    head_pc, pc;
    assign fq.in_ready  = cnt_q < CW'(DEPTH);
    assign fq.out_valid = cnt_q != '0;
    assign enq      = fq.in_valid & fq.in_ready;
    assign deq      = fq.out_valid & fq.out_ready;
    assign hard     = fq.flush & (!fq.keep_ds | (st_q == FQ_WAIT_DS));
    assign keep     = fq.flush & fq.keep_ds & (st_q == FQ_NORMAL);
    assign nxt_rd   = rd_q + AW'(deq);
    assign avail    = cnt_q - CW'(deq) + CW'(enq);
    assign avail_nz = avail != '0;
    // next pointers/count/state; a kept delay slot is always the word at nxt_rd, stored or incoming
    always_comb begin
        rd_d  = nxt_rd;
        wr_d  = wr_q + AW'(enq);
        cnt_d = avail;
        st_d  = st_q;
        if (hard) begin
            rd_d  = wr_q;
            wr_d  = wr_q;
            cnt_d = '0;
            st_d  = FQ_NORMAL;
        end else if (keep) begin
            wr_d  = nxt_rd + AW'(avail_nz);
            cnt_d = CW'(avail_nz);
            st_d  = avail_nz ? FQ_NORMAL : FQ_WAIT_DS;
        end else if (enq) begin
            st_d  = FQ_NORMAL;
        end
    end
    // queue control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            st_q  <= FQ_NORMAL;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end
    fetch_queue_mem #(.DEPTH(DEPTH), .W(32 + PC_W)) u_mem (
        .clk     (clk),
        .we_i    (enq),
        .waddr_i (wr_q),
        .wdata_i ({fq.in_ins, fq.in_pc}),
        .raddr_i (rd_q),
        .rdata_o ({head_ins, head_pc})
    );
    assign ins         = fq.out_valid ? head_ins : NOP_INS;
    assign pc          = fq.out_valid ? head_pc : '0;
    assign fq.out_ins  = ins;
    assign fq.out_pc   = pc;
    assign fq.out_pc8  = pc + PC_W'(8);
    assign fq.op       = ins[OP_HI:OP_LO];
    assign fq.rs       = ins[RS_HI:RS_LO];
    assign fq.rt       = ins[RT_HI:RT_LO];
    assign fq.rd       = ins[RD_HI:RD_LO];
    assign fq.shamt    = ins[SH_HI:SH_LO];
    assign fq.funct    = ins[FN_HI:FN_LO];
    assign fq.imm16    = ins[IMM_HI:IMM_LO];
    assign fq.addr26   = ins[ADDR_HI:ADDR_LO];
    assign fq.count    = cnt_q;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_q, flushed_q, lost;
    assign lost = hard ? 32'(avail) : keep ? 32'(avail) - 32'(avail_nz) : 32'd0;
    // stall cycles and words discarded by redirects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q   <= '0;
            flushed_q <= '0;
        end else begin
            stall_q   <= stall_q + 32'(fq.in_valid & !fq.in_ready);
            flushed_q <= flushed_q + lost;
        end
    end
    assign perf_stall   = stall_q;
    assign perf_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, corner sequences and a scoreboard model for fetch_queue
module tb_fetch_queue;
    import fetch_queue_pkg::*;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;
    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        kd;
        int          exp_cnt;
        logic [31:0] exp_pc;
        logic        exp_rdy;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    ent_t mq[$];
    bit wait_m = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) fq ();
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall, perf_flushed;
`endif
    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_stall   (perf_stall),
        .perf_flushed (perf_flushed)
`endif
    );
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_ins, e_pc;
        e_ins = NOP_INS;
        e_pc  = '0;
        if (mq.size() != 0) begin
            e_ins = mq[0].ins;
            e_pc  = mq[0].pc;
        end
        chk("count", 32'(fq.count), mq.size());
        chk("out_valid", 32'(fq.out_valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(fq.in_ready), 32'(mq.size() < DEPTH));
        chk("out_ins", fq.out_ins, e_ins);
        chk("out_pc", fq.out_pc, e_pc);
        chk("out_pc8", fq.out_pc8, e_pc + 32'd8);
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_stall", perf_stall, m_stall);
        chk("perf_flushed", perf_flushed, m_flush);
`endif
    endtask

    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic kd);
        bit enq, deq;
        int avail;
        fq.in_valid  = iv;
        fq.in_ins    = ins;
        fq.in_pc     = pc;
        fq.out_ready = ordy;
        fq.flush     = fl;
        fq.keep_ds   = kd;
        enq = iv && (mq.size() < DEPTH);
        deq = ordy && (mq.size() != 0);
        if (iv && !enq) m_stall++;
        @(posedge clk);
        avail = mq.size() - int'(deq) + int'(enq);
        if (deq) void'(mq.pop_front());
        if (fl && (!kd || wait_m)) begin
            m_flush += 32'(avail);
            mq.delete();
            wait_m = 1'b0;
        end else if (fl) begin
            if (avail != 0) m_flush += 32'(avail - 1);
            if (mq.size() != 0) begin
                while (mq.size() > 1) void'(mq.pop_back());
            end else if (enq) begin
                mq.push_back('{ins, pc});
            end else begin
                wait_m = 1'b1;
            end
        end else if (enq) begin
            mq.push_back('{ins, pc});
            wait_m = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t tbl[18];
        logic [31:0] rpc;
        tbl[0]  = '{1'b1, 32'h1111_1111, 32'h3000, 1'b0, 1'b0, 1'b0, 1, 32'h3000, 1'b1};
        tbl[1]  = '{1'b1, 32'h2222_2222, 32'h3004, 1'b0, 1'b0, 1'b0, 2, 32'h3000, 1'b1};
        tbl[2]  = '{1'b1, 32'h3333_3333, 32'h3008, 1'b0, 1'b0, 1'b0, 3, 32'h3000, 1'b1};
        tbl[3]  = '{1'b1, 32'h4444_4444, 32'h300C, 1'b0, 1'b0, 1'b0, 4, 32'h3000, 1'b0};
        tbl[4]  = '{1'b1, 32'h5555_5555, 32'h3010, 1'b0, 1'b0, 1'b0, 4, 32'h3000, 1'b0};
        tbl[5]  = '{1'b1, 32'h5555_5555, 32'h3010, 1'b1, 1'b0, 1'b0, 3, 32'h3004, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,         32'h0,    1'b1, 1'b0, 1'b0, 2, 32'h3008, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,         32'h0,    1'b1, 1'b0, 1'b0, 1, 32'h300C, 1'b1};
        tbl[8]  = '{1'b0, 32'h0,         32'h0,    1'b1, 1'b0, 1'b0, 0, 32'h0,    1'b1};
        tbl[9]  = '{1'b1, 32'hC0DE_0000, 32'h3100, 1'b0, 1'b0, 1'b0, 1, 32'h3100, 1'b1};
        tbl[10] = '{1'b1, 32'hC0DE_0001, 32'h3104, 1'b0, 1'b0, 1'b0, 2, 32'h3100, 1'b1};
        tbl[11] = '{1'b1, 32'hC0DE_0002, 32'h3108, 1'b1, 1'b0, 1'b0, 2, 32'h3104, 1'b1};
        tbl[12] = '{1'b1, 32'hC0DE_0003, 32'h310C, 1'b1, 1'b0, 1'b0, 2, 32'h3108, 1'b1};
        tbl[13] = '{1'b1, 32'hC0DE_0004, 32'h3110, 1'b1, 1'b0, 1'b0, 2, 32'h310C, 1'b1};
        tbl[14] = '{1'b1, 32'hC0DE_0005, 32'h3114, 1'b1, 1'b0, 1'b0, 2, 32'h3110, 1'b1};
        tbl[15] = '{1'b1, 32'hC0DE_0006, 32'h3118, 1'b1, 1'b0, 1'b0, 2, 32'h3114, 1'b1};
        tbl[16] = '{1'b0, 32'h0,         32'h0,    1'b1, 1'b0, 1'b0, 1, 32'h3118, 1'b1};
        tbl[17] = '{1'b0, 32'h0,         32'h0,    1'b1, 1'b0, 1'b0, 0, 32'h0,    1'b1};
        fq.in_valid = 1'b0; fq.in_ins = '0; fq.in_pc = '0;
        fq.out_ready = 1'b0; fq.flush = 1'b0; fq.keep_ds = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_out_pc8", fq.out_pc8, 32'h8);
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].iv, tbl[i].ins, tbl[i].pc, tbl[i].ordy, tbl[i].fl, tbl[i].kd);
            chk($sformatf("tbl%0d_count", i), 32'(fq.count), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_out_pc", i), fq.out_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_in_ready", i), 32'(fq.in_ready), 32'(tbl[i].exp_rdy));
        end
        cycle(1'b1, 32'h8C88_0004, 32'h3010, 1'b0, 1'b0, 1'b0);
        chk("f_pc8", fq.out_pc8, 32'h3018);
        chk("f_op", 32'(fq.op), 32'h23);
        chk("f_rs", 32'(fq.rs), 32'h4);
        chk("f_rt", 32'(fq.rt), 32'h8);
        chk("f_rd", 32'(fq.rd), 32'h0);
        chk("f_shamt", 32'(fq.shamt), 32'h0);
        chk("f_funct", 32'(fq.funct), 32'h4);
        chk("f_imm16", 32'(fq.imm16), 32'h4);
        chk("f_addr26", 32'(fq.addr26), 32'h088_0004);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h1000_0003, 32'h3000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hAAAA_0001, 32'h3004, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hBBBB_0002, 32'h3008, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hCCCC_0003, 32'h300C, 1'b1, 1'b1, 1'b1);
        chk("ds_count", 32'(fq.count), 32'd1);
        chk("ds_out_pc", fq.out_pc, 32'h3004);
        chk("ds_out_ins", fq.out_ins, 32'hAAAA_0001);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("ds_empty", 32'(fq.out_valid), 32'd0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("wds_state", 32'(dut.st_q), 32'(FQ_WAIT_DS));
        cycle(1'b1, 32'h2400_0001, 32'h4000, 1'b0, 1'b0, 1'b0);
        chk("wds_back_normal", 32'(dut.st_q), 32'(FQ_NORMAL));
        cycle(1'b1, 32'h2400_0002, 32'h4004, 1'b0, 1'b0, 1'b0);
        chk("wds_count", 32'(fq.count), 32'd2);
        chk("wds_head", fq.out_pc, 32'h4000);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("wds_second", fq.out_pc, 32'h4004);
        idle();
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h5000_0000, 32'h5000, 1'b0, 1'b1, 1'b1);
        chk("wds_reflush_count", 32'(fq.count), 32'd0);
        chk("wds_reflush_state", 32'(dut.st_q), 32'(FQ_NORMAL));
        cycle(1'b1, 32'h5000_0004, 32'h5004, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h5000_0008, 32'h5008, 1'b1, 1'b1, 1'b1);
        chk("ds_incoming_pc", fq.out_pc, 32'h5008);
        chk("ds_incoming_count", 32'(fq.count), 32'd1);
        cycle(1'b1, 32'h5000_000C, 32'h500C, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h5000_0010, 32'h5010, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h5000_0014, 32'h5014, 1'b0, 1'b1, 1'b0);
        chk("hard_flush_count", 32'(fq.count), 32'd0);
        rpc = RESET_PC;
        for (int i = 0; i < 160; i++) begin
            logic iv, fl;
            iv = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 11) == 0;
            cycle(iv, $urandom, rpc, 1'($urandom_range(0, 1)), fl, 1'($urandom_range(0, 1)));
            if (iv) rpc += 32'd4;
        end
        while (mq.size() < 3) cycle(1'b1, 32'h6000_0000 + 32'(mq.size()), 32'h6000, 1'b0, 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        chk("areset_out_valid", 32'(fq.out_valid), 32'd0);
        chk("areset_in_ready", 32'(fq.in_ready), 32'd1);
        chk("areset_count", 32'(fq.count), 32'd0);
        chk("areset_out_ins", fq.out_ins, 32'h0);
        chk("areset_out_pc8", fq.out_pc8, 32'h8);
        mq.delete();
        wait_m = 1'b0;
        m_stall = '0;
        m_flush = '0;
        @(negedge clk);
        reset = 1'b0;
        check_outputs();
        cycle(1'b1, 32'h7000_0000, 32'h7000, 1'b0, 1'b0, 1'b0);
        chk("post_reset_pc", fq.out_pc, 32'h7000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
